mac_lut_nway: RTL and testbench

- Parametrised N-way set-associative MAC learning/forwarding table for the TSN switch, replacing the single-way 4-port table.
- Per request it looks up dst MAC to a forwarding port bitmap, then learns/refreshes the src MAC.
- Performs background aging sweeps, with eviction and station-move handling.
- Sits between the frame header parser (hash/MAC extraction) and the port enqueue logic.

---
 rtl/mac_lut_nway.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_mac_lut_nway.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_lut_nway.sv
// N-way set-associative MAC learning/forwarding table with background aging sweeps.
// Define LUT_STATS_EN to add saturating hit/miss/learn/evict counters.
module mac_lut_nway #(
   parameter int unsigned NUM_PORTS = 4,
   parameter int unsigned HASH_W    = 9,
   parameter int unsigned WAYS      = 2,
   parameter int unsigned AGE_W     = 10,
   parameter int unsigned LIVE_TH   = 300,
   localparam int unsigned PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 se_req_i,
   input  logic [47:0]          dst_mac_i,
   input  logic [47:0]          src_mac_i,
   input  logic [HASH_W-1:0]    dst_hash_i,
   input  logic [HASH_W-1:0]    src_hash_i,
   input  logic [PW-1:0]        src_port_i,
   output logic                 se_busy_o,
   output logic                 se_ack_o,
   output logic                 se_nak_o,
   output logic [NUM_PORTS-1:0] search_result_o,
   input  logic                 aging_req_i,
   output logic                 aging_ack_o,
`ifdef LUT_STATS_EN
   output logic [31:0]          hit_cnt_o,
   output logic [31:0]          miss_cnt_o,
   output logic [31:0]          learn_cnt_o,
   output logic [31:0]          evict_cnt_o,
`endif
   output logic                 init_done_o
);

   localparam int unsigned DEPTH = 2 ** HASH_W;
   localparam int unsigned WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [AGE_W-1:0]     LiveAge = AGE_W'(LIVE_TH);
   localparam logic [NUM_PORTS-1:0] PortOne = NUM_PORTS'(1);

   typedef struct packed {
      logic             valid;
      logic [AGE_W-1:0] age;
      logic [47:0]      mac;
      logic [PW-1:0]    port;
   } entry_t;
   typedef entry_t [WAYS-1:0] row_t;

   typedef enum logic [3:0] {
      StInit, StIdle, StDstRd, StDstChk, StSrcRd, StSrcChk, StSrcWr, StAgeRd, StAgeChk, StAgeWr
   } state_e;

   state_e               state_q, state_d;
   row_t                 mem [DEPTH];
   row_t                 rd_q, wr_row_q, learn_row, age_row;
   logic                 busy_q, ack_q, nak_q, aging_ack_q, init_done_q, aging_pending_q;
   logic [NUM_PORTS-1:0] result_q, pend_res_q, dst_res, flood;
   logic                 pend_ack_q, dst_ack, dst_hit;
   logic [PW-1:0]        dst_port;
   logic [HASH_W-1:0]    init_ptr_q, aging_ptr_q, dst_hash_q, src_hash_q;
   logic [47:0]          dst_mac_q, src_mac_q;
   logic [PW-1:0]        src_port_q;
   logic                 src_match, src_free;
   logic [WW-1:0]        src_mway, src_fway, old_way, tgt_way;
   logic [AGE_W-1:0]     old_age;
   logic                 mem_we, mem_re;
   logic [HASH_W-1:0]    mem_waddr, mem_raddr;
   row_t                 mem_wdata;

   // Row memory: one word per hash row, registered synchronous read.
   always_comb begin
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_waddr = init_ptr_q;
      mem_raddr = dst_hash_q;
      mem_wdata = '0;
      unique case (state_q)
         StInit:  mem_we = 1'b1;
         StDstRd: mem_re = 1'b1;
         StSrcRd: begin
            mem_re    = 1'b1;
            mem_raddr = src_hash_q;
         end
         StAgeRd: begin
            mem_re    = 1'b1;
            mem_raddr = aging_ptr_q;
         end
         StSrcWr: begin
            mem_we    = 1'b1;
            mem_waddr = src_hash_q;
            mem_wdata = wr_row_q;
         end
         StAgeWr: begin
            mem_we    = 1'b1;
            mem_waddr = aging_ptr_q;
            mem_wdata = wr_row_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      if (mem_re) rd_q <= mem[mem_raddr];
   end

   // Destination lookup; descending scan so the lowest matching way wins.
   always_comb begin
      dst_hit  = 1'b0;
      dst_port = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (rd_q[w].valid && rd_q[w].mac == dst_mac_q) begin
            dst_hit  = 1'b1;
            dst_port = rd_q[w].port;
         end
      end
      flood = ~(PortOne << src_port_q);
      if (dst_mac_q[40] || !dst_hit) begin
         dst_ack = 1'b0;
         dst_res = flood;
      end else begin
         dst_ack = 1'b1;
         dst_res = (dst_port == src_port_q) ? '0 : (PortOne << dst_port);
      end
   end

   // Source learning: refresh match, else lowest free way, else oldest (lowest index on tie).
   always_comb begin
      src_match = 1'b0;
      src_free  = 1'b0;
      src_mway  = '0;
      src_fway  = '0;
      old_way   = '0;
      old_age   = '1;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (rd_q[w].valid && rd_q[w].mac == src_mac_q) begin
            src_match = 1'b1;
            src_mway  = WW'(w);
         end
         if (!rd_q[w].valid) begin
            src_free = 1'b1;
            src_fway = WW'(w);
         end
         if (rd_q[w].age <= old_age) begin
            old_age = rd_q[w].age;
            old_way = WW'(w);
         end
      end
      tgt_way   = src_match ? src_mway : (src_free ? src_fway : old_way);
      learn_row = rd_q;
      if (!src_mac_q[40]) begin
         learn_row[tgt_way].valid = 1'b1;
         learn_row[tgt_way].age   = LiveAge;
         learn_row[tgt_way].mac   = src_mac_q;
         learn_row[tgt_way].port  = src_port_q;
      end
   end

   always_comb begin
      age_row = rd_q;
      for (int w = 0; w < WAYS; w++) begin
         if (rd_q[w].valid) begin
            if (rd_q[w].age == '0) age_row[w] = '0;
            else                   age_row[w].age = rd_q[w].age - 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StInit:   if (init_ptr_q == '1) state_d = StIdle;
         StIdle: begin
            if (se_req_i)             state_d = StDstRd;
            else if (aging_pending_q) state_d = StAgeRd;
         end
         StDstRd:  state_d = StDstChk;
         StDstChk: state_d = StSrcRd;
         StSrcRd:  state_d = StSrcChk;
         StSrcChk: state_d = StSrcWr;
         StSrcWr:  state_d = StIdle;
         StAgeRd:  state_d = StAgeChk;
         StAgeChk: state_d = StAgeWr;
         StAgeWr:  state_d = StIdle;
         default:  state_d = StInit;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= StInit;
         busy_q          <= 1'b0;
         ack_q           <= 1'b0;
         nak_q           <= 1'b0;
         result_q        <= '0;
         aging_ack_q     <= 1'b0;
         init_done_q     <= 1'b0;
         aging_pending_q <= 1'b0;
         aging_ptr_q     <= '0;
         init_ptr_q      <= '0;
         dst_mac_q       <= '0;
         src_mac_q       <= '0;
         dst_hash_q      <= '0;
         src_hash_q      <= '0;
         src_port_q      <= '0;
         pend_ack_q      <= 1'b0;
         pend_res_q      <= '0;
         wr_row_q        <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= (state_d != StIdle);
         ack_q       <= 1'b0;
         nak_q       <= 1'b0;
         aging_ack_q <= 1'b0;
         if (aging_req_i && !aging_pending_q) begin
            aging_pending_q <= 1'b1;
            aging_ptr_q     <= '0;
         end
         unique case (state_q)
            StInit: begin
               init_ptr_q <= init_ptr_q + 1'b1;
               if (init_ptr_q == '1) init_done_q <= 1'b1;
            end
            StIdle: begin
               if (se_req_i) begin
                  dst_mac_q  <= dst_mac_i;
                  src_mac_q  <= src_mac_i;
                  dst_hash_q <= dst_hash_i;
                  src_hash_q <= src_hash_i;
                  src_port_q <= src_port_i;
               end
            end
            StDstChk: begin
               pend_ack_q <= dst_ack;
               pend_res_q <= dst_res;
            end
            // Result is held back so ack/nak land on the fourth edge after acceptance.
            StSrcChk: begin
               wr_row_q <= learn_row;
               ack_q    <= pend_ack_q;
               nak_q    <= !pend_ack_q;
               result_q <= pend_res_q;
            end
            StAgeChk: wr_row_q <= age_row;
            StAgeWr: begin
               aging_ptr_q <= aging_ptr_q + 1'b1;
               if (aging_ptr_q == '1) begin
                  aging_ack_q     <= 1'b1;
                  aging_pending_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign se_busy_o       = busy_q;
   assign se_ack_o        = ack_q;
   assign se_nak_o        = nak_q;
   assign search_result_o = result_q;
   assign aging_ack_o     = aging_ack_q;
   assign init_done_o     = init_done_q;

`ifdef LUT_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q, learn_cnt_q, evict_cnt_q;
   logic [2:0]  age_removed;
   logic        learn_new;

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [2:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {30'd0, b};
      return s[32] ? '1 : s[31:0];
   endfunction

   always_comb begin
      age_removed = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (rd_q[w].valid && rd_q[w].age == '0) age_removed = age_removed + 3'd1;
      end
   end

   assign learn_new = !src_mac_q[40] && !src_match;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
         learn_cnt_q <= '0;
         evict_cnt_q <= '0;
      end else if (state_q == StSrcChk) begin
         if (pend_ack_q) hit_cnt_q  <= sat_add(hit_cnt_q, 3'd1);
         else            miss_cnt_q <= sat_add(miss_cnt_q, 3'd1);
         if (learn_new)  learn_cnt_q <= sat_add(learn_cnt_q, 3'd1);
         if (learn_new && !src_free) evict_cnt_q <= sat_add(evict_cnt_q, 3'd1);
      end else if (state_q == StAgeChk) begin
         evict_cnt_q <= sat_add(evict_cnt_q, age_removed);
      end
   end

   assign hit_cnt_o   = hit_cnt_q;
   assign miss_cnt_o  = miss_cnt_q;
   assign learn_cnt_o = learn_cnt_q;
   assign evict_cnt_o = evict_cnt_q;
`endif

endmodule

// File: tb/tb_mac_lut_nway.sv
// Self-checking bench for mac_lut_nway: directed plan steps plus randomized traffic
// checked against an array-based table model.
module tb_mac_lut_nway;
   localparam int unsigned NP = 4, HW = 4, WY = 2, AW = 10, LT = 2;
   localparam int unsigned PW = 2, DEPTH = 16;

   logic          clk = 1'b0, rst_n = 1'b0, se_req = 1'b0, aging_req = 1'b0;
   logic [47:0]   dst_mac = '0, src_mac = '0;
   logic [HW-1:0] dst_hash = '0, src_hash = '0;
   logic [PW-1:0] src_port = '0;
   logic          se_busy, se_ack, se_nak, aging_ack, init_done;
   logic [NP-1:0] search_result;
`ifdef LUT_STATS_EN
   logic [31:0]   hit_cnt, miss_cnt, learn_cnt, evict_cnt;
`endif

   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   mac_lut_nway #(
      .NUM_PORTS(NP), .HASH_W(HW), .WAYS(WY), .AGE_W(AW), .LIVE_TH(LT)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .se_req_i        (se_req),
      .dst_mac_i       (dst_mac),
      .src_mac_i       (src_mac),
      .dst_hash_i      (dst_hash),
      .src_hash_i      (src_hash),
      .src_port_i      (src_port),
      .se_busy_o       (se_busy),
      .se_ack_o        (se_ack),
      .se_nak_o        (se_nak),
      .search_result_o (search_result),
      .aging_req_i     (aging_req),
      .aging_ack_o     (aging_ack),
`ifdef LUT_STATS_EN
      .hit_cnt_o       (hit_cnt),
      .miss_cnt_o      (miss_cnt),
      .learn_cnt_o     (learn_cnt),
      .evict_cnt_o     (evict_cnt),
`endif
      .init_done_o     (init_done)
   );

   // Reference table
   bit          m_v    [DEPTH][WY];
   int unsigned m_age  [DEPTH][WY];
   logic [47:0] m_mac  [DEPTH][WY];
   int unsigned m_port [DEPTH][WY];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int r = 0; r < DEPTH; r++)
         for (int w = 0; w < WY; w++) begin
            m_v[r][w] = 0; m_age[r][w] = 0; m_mac[r][w] = '0; m_port[r][w] = 0;
         end
   endtask

   task automatic model_lookup(input logic [47:0] d, input int h, input int sp,
                               output bit ack, output logic [NP-1:0] res);
      logic [NP-1:0] flood;
      int hit_w;
      flood = '1;
      flood[sp] = 1'b0;
      hit_w = -1;
      if (!d[40])
         for (int w = 0; w < WY; w++)
            if (hit_w < 0 && m_v[h][w] && m_mac[h][w] == d) hit_w = w;
      if (hit_w < 0) begin
         ack = 0; res = flood;
      end else begin
         ack = 1; res = '0;
         if (m_port[h][hit_w] != sp) res[m_port[h][hit_w]] = 1'b1;
      end
   endtask

   task automatic model_learn(input logic [47:0] s, input int h, input int sp);
      int t;
      t = -1;
      if (s[40]) return;
      for (int w = 0; w < WY; w++) if (t < 0 && m_v[h][w] && m_mac[h][w] == s) t = w;
      for (int w = 0; w < WY; w++) if (t < 0 && !m_v[h][w]) t = w;
      if (t < 0) begin
         t = 0;
         for (int w = 1; w < WY; w++) if (m_age[h][w] < m_age[h][t]) t = w;
      end
      m_v[h][t] = 1; m_age[h][t] = LT; m_mac[h][t] = s; m_port[h][t] = sp;
   endtask

   task automatic model_age();
      for (int r = 0; r < DEPTH; r++)
         for (int w = 0; w < WY; w++)
            if (m_v[r][w]) begin
               if (m_age[r][w] == 0) begin m_v[r][w] = 0; m_mac[r][w] = '0; m_port[r][w] = 0; end
               else m_age[r][w] = m_age[r][w] - 1;
            end
   endtask

   // Called at a negedge; returns at a negedge.
   task automatic do_search(input string tag, input logic [47:0] d, input logic [47:0] s,
                            input int dh, input int sh, input int sp,
                            output bit o_ack, output logic [NP-1:0] o_res);
      bit e_ack;
      logic [NP-1:0] e_res;
      int n;
      n = 0;
      o_ack = 0; o_res = '0;
      while ((se_busy !== 1'b0 || init_done !== 1'b1) && n < 500) begin
         @(negedge clk); n++;
      end
      chk({tag, "_idle_wait"}, (n < 500), 1);
      se_req = 1'b1; dst_mac = d; src_mac = s;
      dst_hash = HW'(dh); src_hash = HW'(sh); src_port = PW'(sp);
      @(posedge clk);
      model_lookup(d, dh, sp, e_ack, e_res);
      model_learn(s, sh, sp);
      @(negedge clk);
      se_req = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         if (k == 3) chk({tag, "_early_pulse"}, {se_ack, se_nak}, 2'b00);
         else if (k == 4) begin
            chk({tag, "_busy"}, se_busy, 1);
            chk({tag, "_ack"}, se_ack, e_ack);
            chk({tag, "_nak"}, se_nak, !e_ack);
            chk({tag, "_result"}, search_result, e_res);
            o_ack = se_ack; o_res = search_result;
         end else if (k == 5) begin
            chk({tag, "_pulse_end"}, {se_ack, se_nak}, 2'b00);
            chk({tag, "_result_hold"}, search_result, e_res);
         end
      end
      @(negedge clk);
   endtask

   task automatic pulse_aging();
      aging_req = 1'b1;
      @(negedge clk);
      aging_req = 1'b0;
   endtask

   task automatic wait_aging(input string tag);
      int n;
      bit seen;
      n = 0; seen = 0;
      while (!seen && n < 2000) begin
         @(posedge clk); #1; n++;
         if (aging_ack === 1'b1) seen = 1;
      end
      chk({tag, "_aging_ack"}, seen, 1);
      @(posedge clk); #1;
      chk({tag, "_aging_ack_pulse"}, aging_ack, 0);
      model_age();
      @(negedge clk);
   endtask

   task automatic release_and_init(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      rst_n = 1'b1;
      while (init_done !== 1'b1 && n < 200) begin
         @(posedge clk); #1; n++;
         if (n == 1) chk({tag, "_busy_init"}, se_busy, 1);
      end
      chk({tag, "_init_cycles"}, n, DEPTH);
      chk({tag, "_busy_after_init"}, se_busy, 0);
      model_clear();
      @(negedge clk);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      bit            a;
      logic [NP-1:0] r;
      logic [47:0]   pool [8];
      localparam logic [47:0] X0  = 48'h0011_2233_4455;
      localparam logic [47:0] S0  = 48'h0200_0000_00AA;
      localparam logic [47:0] GRP = 48'h0100_0000_0001;
      localparam logic [47:0] MA  = 48'h0200_0000_0A0A;
      localparam logic [47:0] MB  = 48'h0200_0000_0B0B;
      localparam logic [47:0] M1  = 48'h0200_0000_0C01;
      localparam logic [47:0] M2  = 48'h0200_0000_0C02;
      localparam logic [47:0] M3  = 48'h0200_0000_0C03;
      localparam logic [47:0] MG  = 48'h0300_0000_0D0D;
      localparam logic [47:0] ME  = 48'h0200_0000_0E0E;
      localparam logic [47:0] MF  = 48'h0200_0000_0F0F;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {se_busy, se_ack, se_nak, aging_ack, init_done, search_result}, '0);
      release_and_init("boot");

      do_search("first", X0, S0, 2, 1, 1, a, r);
      chk("tp_first_nak", a, 0);
      chk("tp_first_res", r, 4'b1101);

      do_search("learn_a", X0, MA, 2, 5, 2, a, r);
      do_search("hit_a_p0", MA, GRP, 5, 3, 0, a, r);
      chk("tp_hit_a_res", {a, r}, {1'b1, 4'b0100});
      do_search("hit_a_p2", MA, GRP, 5, 3, 2, a, r);
      chk("tp_filter_a_res", {a, r}, {1'b1, 4'b0000});

      do_search("learn_b_p1", X0, MB, 2, 6, 1, a, r);
      do_search("move_before", MB, GRP, 6, 3, 0, a, r);
      chk("tp_move_before", r, 4'b0010);
      do_search("learn_b_p3", X0, MB, 2, 6, 3, a, r);
      do_search("move_after", MB, GRP, 6, 3, 0, a, r);
      chk("tp_move_after", r, 4'b1000);

      do_search("learn_m1", X0, M1, 2, 7, 1, a, r);
      pulse_aging();
      wait_aging("sweep_evict");
      do_search("learn_m2", X0, M2, 2, 7, 2, a, r);
      do_search("learn_m3", X0, M3, 2, 7, 3, a, r);
      do_search("evicted_m1", M1, GRP, 7, 3, 0, a, r);
      chk("tp_evicted_m1", a, 0);
      do_search("kept_m2", M2, GRP, 7, 3, 0, a, r);
      chk("tp_kept_m2", {a, r}, {1'b1, 4'b0100});

      // Group source aimed at the full row 7 must not displace M3.
      do_search("bcast", 48'hFFFF_FFFF_FFFF, MG, 3, 7, 3, a, r);
      chk("tp_bcast", {a, r}, {1'b0, 4'b0111});
      do_search("m3_after_grp", M3, GRP, 7, 3, 0, a, r);
      chk("tp_m3_after_grp", {a, r}, {1'b1, 4'b1000});

      do_search("learn_e", X0, ME, 2, 0, 1, a, r);
      pulse_aging();
      wait_aging("sweep1");
      pulse_aging();
      repeat (2) @(negedge clk);
      do_search("mid_sweep", ME, GRP, 0, 3, 0, a, r);
      chk("tp_mid_sweep", {a, r}, {1'b1, 4'b0010});
      repeat (20) @(negedge clk);
      pulse_aging();
      wait_aging("sweep2");
      do_search("e_after2", ME, GRP, 0, 3, 0, a, r);
      chk("tp_e_after2", a, 1);
      pulse_aging();
      wait_aging("sweep3");
      do_search("e_after3", ME, GRP, 0, 3, 0, a, r);
      chk("tp_e_after3", {a, r}, {1'b0, 4'b1110});

      for (int i = 0; i < 8; i++) pool[i] = 48'h0200_0000_1000 + 48'(i);
      for (int it = 0; it < 60; it++) begin
         int sel, di, si, dh;
         logic [47:0] d, s;
         sel = $urandom_range(0, 9);
         di = $urandom_range(0, 7);
         si = $urandom_range(0, 7);
         if (sel == 0) begin
            pulse_aging();
            wait_aging("rnd_sweep");
         end else begin
            d = pool[di];
            dh = 10 + (di % 4);
            s = (sel == 2) ? (48'h0100_0000_2000 + 48'(si)) : pool[si];
            if (sel == 1) begin
               d = 48'h0100_0000_3000 + 48'($urandom_range(0, 255));
               dh = $urandom_range(0, DEPTH - 1);
            end
            do_search("rnd", d, s, dh, 10 + (si % 4), $urandom_range(0, NP - 1), a, r);
         end
      end

      // Reset in the middle of a transaction clears the table.
      do_search("learn_f", X0, MF, 2, 4, 2, a, r);
      se_req = 1'b1; dst_mac = MF; src_mac = GRP; dst_hash = 4'd4; src_hash = 4'd3;
      src_port = 2'd0;
      @(posedge clk);
      @(negedge clk);
      se_req = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_outputs", {se_busy, se_ack, se_nak, aging_ack, init_done, search_result}, '0);
      release_and_init("reinit");
      do_search("f_after_reset", MF, GRP, 4, 3, 0, a, r);
      chk("tp_f_after_reset", {a, r}, {1'b0, 4'b1110});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
